sw_ctrl_fsm: RTL

SW_CTRL_FSM -- requirements
Module: sw_ctrl_fsm

---
 rtl/stopwatch_pkg.sv | 10 +
 rtl/sw_ctrl_fsm_if.sv | 11 +
 rtl/debounce_bit.sv | 45 ++++
 rtl/sw_ctrl_fsm.sv | 83 ++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state encoding and default timing parameters for the stopwatch control block
package stopwatch_pkg;
    localparam int DEF_SAMPLE_DIV = 50000;
    localparam int DEF_DB_COUNT   = 16;
    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LAP     = 2'd2
    } state_t;
endpackage

// File: rtl/sw_ctrl_fsm_if.sv
// sw_ctrl_fsm_if: button and control bus of the stopwatch controller
// sw: raw buttons in; sw_db: debounced levels; run/freeze: levels; clear: one-cycle pulse
interface sw_ctrl_fsm_if;
    logic [1:0] sw;
    logic [1:0] sw_db;
    logic       run;
    logic       freeze;
    logic       clear;
    modport master (output sw, input sw_db, run, freeze, clear);
    modport slave (input sw, output sw_db, run, freeze, clear);
endinterface

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchronizer, tick-sampled debounce counter, stable level and rising-edge press pulse
// i_clk/i_rst: clock, sync reset; i_tick: sample strobe; i_sw: raw button; o_db: stable level; o_press: 1-cycle press
module debounce_bit
    import stopwatch_pkg::*;
#(
    parameter int DB_COUNT = DEF_DB_COUNT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_sw,
    output logic o_db,
    output logic o_press
);
    localparam int CW = $clog2(DB_COUNT + 1);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          r_db_d;
    logic [CW-1:0] w_cnt_inc;
    assign w_cnt_inc = r_cnt + CW'(1);
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_db_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_sw};
            r_db_d <= r_db;
            if (i_tick) begin
                if (r_sync[1] == r_db) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc == CW'(DB_COUNT)) begin
                    r_db  <= r_sync[1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end
    assign o_db    = r_db;
    assign o_press = r_db & ~r_db_d;
endmodule

// File: rtl/sw_ctrl_fsm.sv
// sw_ctrl_fsm: stopwatch start/stop and lap/clear control from two debounced buttons
// clk0/rst: clock, sync active-high reset; bus: sw in, sw_db/run/freeze/clear out
module sw_ctrl_fsm
    import stopwatch_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int DB_COUNT   = DEF_DB_COUNT
) (
    input  logic         clk0,
    input  logic         rst,
    sw_ctrl_fsm_if.slave bus
);
    localparam int DW = $clog2(SAMPLE_DIV + 1);
    logic [DW-1:0] r_div;
    logic          w_tick;
    logic [1:0]    w_db;
    logic [1:0]    w_press;
    state_t        r_state;
    logic          r_run;
    logic          r_freeze;
    logic          r_clear;
    assign w_tick = r_div == DW'(SAMPLE_DIV - 1);
    always_ff @(posedge clk0) r_div <= (rst || w_tick) ? '0 : r_div + DW'(1);
    for (genvar i = 0; i < 2; i++) begin : g_db
        debounce_bit #(.DB_COUNT(DB_COUNT)) u_db (
            .i_clk   (clk0),
            .i_rst   (rst),
            .i_tick  (w_tick),
            .i_sw    (bus.sw[i]),
            .o_db    (w_db[i]),
            .o_press (w_press[i])
        );
    end
    // press0 is tested first in every state, so a simultaneous press1 is dropped
    always_ff @(posedge clk0) begin
        if (rst) begin
            r_state  <= ST_STOPPED;
            r_run    <= 1'b0;
            r_freeze <= 1'b0;
            r_clear  <= 1'b0;
        end else begin
            r_clear <= 1'b0;
            case (r_state)
                ST_STOPPED: begin
                    if (w_press[0]) begin
                        r_state <= ST_RUNNING;
                        r_run   <= 1'b1;
                    end else begin
                        r_clear <= w_press[1];
                    end
                end
                ST_RUNNING: begin
                    if (w_press[0]) begin
                        r_state <= ST_STOPPED;
                        r_run   <= 1'b0;
                    end else if (w_press[1]) begin
                        r_state  <= ST_LAP;
                        r_freeze <= 1'b1;
                    end
                end
                ST_LAP: begin
                    if (w_press[0]) begin
                        r_state  <= ST_STOPPED;
                        r_run    <= 1'b0;
                        r_freeze <= 1'b0;
                    end else if (w_press[1]) begin
                        r_state  <= ST_RUNNING;
                        r_freeze <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_STOPPED;
                    r_run    <= 1'b0;
                    r_freeze <= 1'b0;
                end
            endcase
        end
    end
    assign bus.sw_db  = w_db;
    assign bus.run    = r_run;
    assign bus.freeze = r_freeze;
    assign bus.clear  = r_clear;
endmodule
